// File: rtl/pc_pkg.sv
// pc_pkg: shared state encoding, default vectors and alignment helper for the PC generator.
package pc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

    // Clears the low log2(bytes) address bits; callers slice to their own width.
    function automatic logic [63:0] align_mask(input int unsigned bytes);
        return ~(64'(bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/redirect_arbiter.sv
// redirect_arbiter: fixed-priority (index 0 first) one-hot select of redirect channels and target mux.
module redirect_arbiter #(
    parameter int NUM_REDIRECT = 3,
    parameter int W            = 32
) (
    input  logic [NUM_REDIRECT-1:0]   i_valid,
    input  logic [NUM_REDIRECT*W-1:0] i_target,
    output logic                      o_any_valid,
    output logic [W-1:0]              o_sel_target
);

    logic [NUM_REDIRECT-1:0] w_onehot;

    // Isolate the lowest set bit so exactly one channel drives the mux.
    assign w_onehot    = i_valid & (~i_valid + NUM_REDIRECT'(1));
    assign o_any_valid = |i_valid;

    always_comb begin
        o_sel_target = '0;
        for (int i = 0; i < NUM_REDIRECT; i++)
            o_sel_target = o_sel_target | ({W{w_onehot[i]}} & i_target[i*W +: W]);
    end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: IF-stage program counter with trap, prioritised redirects, req/gnt fetch and halt/resume.
module pc_gen_unit
    import pc_pkg::*;
#(
    parameter int                         INST_ADDR_WIDTH = 32,
    parameter int                         NUM_REDIRECT    = 3,
    parameter logic [INST_ADDR_WIDTH-1:0] RESET_VECTOR    = DEFAULT_RESET_VECTOR,
    parameter logic [INST_ADDR_WIDTH-1:0] TRAP_VECTOR     = DEFAULT_TRAP_VECTOR,
    parameter int                         INST_BYTES      = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    stall_PC,
    input  logic                                    trap_req,
    input  logic [NUM_REDIRECT-1:0]                 redirect_valid,
    input  logic [NUM_REDIRECT*INST_ADDR_WIDTH-1:0] redirect_target,
    input  logic                                    inst_gnt,
    output logic                                    inst_req,
    output logic                                    inst_we_core2mem,
    output logic [INST_ADDR_WIDTH-1:0]              PC,
    output logic [INST_ADDR_WIDTH-1:0]              pre_PC,
    output logic [INST_ADDR_WIDTH-1:0]              trap_epc,
    output logic                                    redirected,
    output logic                                    cpu_halted
);

    localparam int                         W       = INST_ADDR_WIDTH;
    localparam logic [63:0]                MASK64  = align_mask(INST_BYTES);
    localparam logic [W-1:0]               MASK    = MASK64[W-1:0];
    localparam logic [W-1:0]               TRAP_PC = TRAP_VECTOR & MASK;
    localparam logic [W-1:0]               STEP    = W'(INST_BYTES);

    state_t         r_state, w_next_state;
    logic [W-1:0]   r_pc, r_pre_pc, r_trap_epc, w_pc_next, w_sel_target;
    logic           r_redirected, w_redir_next, w_pc_we, w_trap, w_any_valid;

    redirect_arbiter #(.NUM_REDIRECT(NUM_REDIRECT), .W(W)) u_arb (
        .i_valid      (redirect_valid),
        .i_target     (redirect_target),
        .o_any_valid  (w_any_valid),
        .o_sel_target (w_sel_target)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next_state;

    // Leaving HALT goes straight to FETCH so the held PC is resumed, not reloaded.
    always_comb begin
        w_next_state = start ? FETCH : (r_state == FETCH ? HALT : r_state);
        w_pc_next    = r_pc;
        w_pc_we      = 1'b0;
        w_redir_next = 1'b0;
        w_trap       = 1'b0;
        if (r_state == FETCH) begin
            if (trap_req) begin
                w_pc_next    = TRAP_PC;
                w_pc_we      = 1'b1;
                w_redir_next = 1'b1;
                w_trap       = 1'b1;
            end else if (!stall_PC) begin
                if (w_any_valid) begin
                    w_pc_next    = w_sel_target & MASK;
                    w_pc_we      = 1'b1;
                    w_redir_next = 1'b1;
                end else if (inst_gnt) begin
                    w_pc_next = r_pc + STEP;
                    w_pc_we   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_VECTOR;
            r_pre_pc     <= RESET_VECTOR;
            r_trap_epc   <= '0;
            r_redirected <= 1'b0;
        end else begin
            r_redirected <= w_redir_next;
            if (w_pc_we) begin
                r_pc     <= w_pc_next;
                r_pre_pc <= r_pc;
            end
            if (w_trap) r_trap_epc <= r_pc;
        end
    end

    assign inst_req         = (r_state == FETCH) && !stall_PC;
    assign inst_we_core2mem = 1'b0;
    assign PC               = r_pc;
    assign pre_PC           = r_pre_pc;
    assign trap_epc         = r_trap_epc;
    assign redirected       = r_redirected;
    assign cpu_halted       = (r_state == HALT);

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: table-driven directed check of pc_gen_unit plus async-reset sequence.
module tb_pc_gen_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stall_PC = 1'b0, trap_req = 1'b0, inst_gnt = 1'b0;
    logic [2:0]  redirect_valid = '0;
    logic [95:0] redirect_target = '0;
    logic        inst_req, inst_we_core2mem, redirected, cpu_halted;
    logic [31:0] PC, pre_PC, trap_epc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pc_gen_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stall_PC         (stall_PC),
        .trap_req         (trap_req),
        .redirect_valid   (redirect_valid),
        .redirect_target  (redirect_target),
        .inst_gnt         (inst_gnt),
        .inst_req         (inst_req),
        .inst_we_core2mem (inst_we_core2mem),
        .PC               (PC),
        .pre_PC           (pre_PC),
        .trap_epc         (trap_epc),
        .redirected       (redirected),
        .cpu_halted       (cpu_halted)
    );

    typedef struct {
        logic        start, stall, trap, gnt;
        logic [2:0]  rv;
        logic [95:0] tgt;
        logic [31:0] pc, pre, epc;
        logic        redir, req, halt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [95:0] tg(input logic [31:0] c0, c1, c2);
        return {c2, c1, c0};
    endfunction

    task automatic add(input logic st, sl, tr, g, input logic [2:0] rv, input logic [95:0] t,
                       input logic [31:0] pc, pre, epc, input logic rd, rq, h);
        vec_t v;
        v.start = st; v.stall = sl; v.trap = tr; v.gnt = g; v.rv = rv; v.tgt = t;
        v.pc = pc; v.pre = pre; v.epc = epc; v.redir = rd; v.req = rq; v.halt = h;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t v);
        chk({tag, " PC"}, PC, v.pc);
        chk({tag, " pre_PC"}, pre_PC, v.pre);
        chk({tag, " trap_epc"}, trap_epc, v.epc);
        chk({tag, " redirected"}, 32'(redirected), 32'(v.redir));
        chk({tag, " inst_req"}, 32'(inst_req), 32'(v.req));
        chk({tag, " cpu_halted"}, 32'(cpu_halted), 32'(v.halt));
        chk({tag, " we"}, 32'(inst_we_core2mem), 32'd0);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t r;
        logic [95:0] z;
        z = '0;
        //   st sl tr g  rv      targets                              pc            pre           epc     rd rq h
        add(1, 0, 0, 1, 3'b000, z,                                   32'h0,        32'h0,        32'h0,  0, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h4,        32'h0,        32'h0,  0, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h8,        32'h4,        32'h0,  0, 1, 0);
        add(1, 0, 0, 0, 3'b000, z,                                   32'h8,        32'h4,        32'h0,  0, 1, 0);
        add(1, 0, 0, 0, 3'b000, z,                                   32'h8,        32'h4,        32'h0,  0, 1, 0);
        add(1, 0, 0, 0, 3'b000, z,                                   32'h8,        32'h4,        32'h0,  0, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'hC,        32'h8,        32'h0,  0, 1, 0);
        add(1, 0, 0, 1, 3'b110, tg(32'h0, 32'h40, 32'h80),           32'h40,       32'hC,        32'h0,  1, 1, 0);
        add(1, 0, 0, 0, 3'b000, z,                                   32'h40,       32'hC,        32'h0,  0, 1, 0);
        add(1, 0, 0, 0, 3'b101, tg(32'h23, 32'h0, 32'h80),           32'h20,       32'h40,       32'h0,  1, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h24,       32'h20,       32'h0,  0, 1, 0);
        add(1, 0, 0, 0, 3'b001, tg(32'h30, 32'h0, 32'h0),            32'h30,       32'h24,       32'h0,  1, 1, 0);
        add(1, 1, 1, 1, 3'b001, tg(32'h90, 32'h0, 32'h0),            32'h100,      32'h30,       32'h30, 1, 0, 0);
        add(1, 1, 0, 1, 3'b001, tg(32'h90, 32'h0, 32'h0),            32'h100,      32'h30,       32'h30, 0, 0, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h104,      32'h100,      32'h30, 0, 1, 0);
        add(1, 0, 0, 0, 3'b001, tg(32'h18, 32'h0, 32'h0),            32'h18,       32'h104,      32'h30, 1, 1, 0);
        add(0, 0, 0, 0, 3'b000, z,                                   32'h18,       32'h104,      32'h30, 0, 0, 1);
        add(0, 0, 1, 1, 3'b001, tg(32'h90, 32'h0, 32'h0),            32'h18,       32'h104,      32'h30, 0, 0, 1);
        add(0, 0, 0, 1, 3'b011, tg(32'h90, 32'h44, 32'h0),           32'h18,       32'h104,      32'h30, 0, 0, 1);
        add(0, 0, 0, 1, 3'b000, z,                                   32'h18,       32'h104,      32'h30, 0, 0, 1);
        add(0, 0, 0, 1, 3'b100, tg(32'h0, 32'h0, 32'h88),            32'h18,       32'h104,      32'h30, 0, 0, 1);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h18,       32'h104,      32'h30, 0, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h1C,       32'h18,       32'h30, 0, 1, 0);
        add(0, 0, 0, 1, 3'b010, tg(32'h0, 32'h40, 32'h0),            32'h40,       32'h1C,       32'h30, 1, 0, 1);
        add(1, 0, 0, 0, 3'b000, z,                                   32'h40,       32'h1C,       32'h30, 0, 1, 0);
        add(1, 0, 0, 0, 3'b111, tg(32'hFFFF_FFFE, 32'h8, 32'hC),     32'hFFFF_FFFC, 32'h40,      32'h30, 1, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h0,        32'hFFFF_FFFC, 32'h30, 0, 1, 0);
        add(1, 0, 0, 1, 3'b000, z,                                   32'h4,        32'h0,        32'h30, 0, 1, 0);

        r.pc = 32'h0; r.pre = 32'h0; r.epc = 32'h0; r.redir = 0; r.req = 0; r.halt = 0;
        #12;
        chk_all("reset", r);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("idle", r);

        foreach (vecs[i]) begin
            start = vecs[i].start; stall_PC = vecs[i].stall; trap_req = vecs[i].trap;
            inst_gnt = vecs[i].gnt; redirect_valid = vecs[i].rv; redirect_target = vecs[i].tgt;
            step();
            chk_all($sformatf("v%0d", i), vecs[i]);
        end

        // Asynchronous reset between edges must clear everything without a clock.
        #3 rst_n = 1'b0;
        #1;
        chk_all("async_rst", r);
        start = 1'b0; inst_gnt = 1'b1; redirect_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("post_rst_idle", r);
        start = 1'b1;
        step();
        r.req = 1;
        chk_all("post_rst_fetch", r);
        step();
        r.pc = 32'h4;
        chk_all("post_rst_fire", r);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
